// File: rtl/cpu_bus_initiator_pkg.sv
// Shared definitions for the CPU bus initiator: bus widths, stall vector
// width, default timeout and the 2-bit initiator state encoding.
package cpu_bus_initiator_pkg;

    localparam int unsigned WB_ADDR_BUS         = 32;
    localparam int unsigned WB_DATA_BUS         = 32;
    localparam int unsigned STALL_W             = 6;
    localparam int unsigned BUS_TIMEOUT_DEFAULT = 1024;

    typedef enum logic [1:0] {
        BUS_IDLE       = 2'b00,
        BUS_BUSY       = 2'b01,
        BUS_WAIT_STALL = 2'b10
    } bus_state_e;

endpackage

// File: rtl/cpu_bus_initiator.sv
// Bus initiator for one OpenMIPS memory port (IF or MEM). Converts a pipeline
// memory request into a single bus transaction, stalls the pipeline until the
// slave acks, and hands read data back.
//
// Optional feature: define CPU_BUS_TIMEOUT_EN to abort a transaction that has
// not been acked after TIMEOUT_CYCLES BUSY cycles (bus_err_o pulses once).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cpu_ce_i/we_i   CPU request valid / write select
//   cpu_addr_i      byte address, passed to the bus unmodified
//   cpu_data_i      write data
//   cpu_data_o      read data to pipeline (combinational)
//   stall_i         ctrl stall vector, any bit set = pipeline held
//   flush_i         pipeline flush
//   stall_req_o     stall request to ctrl (combinational)
//   bus_err_o       one-cycle timeout pulse (always 0 without the macro)
//   bus_addr_o/bus_data_o/bus_select_o/bus_we_o   registered bus request
//   bus_data_i/bus_ack_i                          slave response
module cpu_bus_initiator
    import cpu_bus_initiator_pkg::*;
#(
    parameter int unsigned ADDR_W         = WB_ADDR_BUS,
    parameter int unsigned DATA_W         = WB_DATA_BUS,
    parameter int unsigned TIMEOUT_CYCLES = BUS_TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_ce_i,
    input  logic               cpu_we_i,
    input  logic [ADDR_W-1:0]  cpu_addr_i,
    input  logic [DATA_W-1:0]  cpu_data_i,
    output logic [DATA_W-1:0]  cpu_data_o,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    output logic               stall_req_o,
    output logic               bus_err_o,
    output logic [ADDR_W-1:0]  bus_addr_o,
    output logic [DATA_W-1:0]  bus_data_o,
    input  logic [DATA_W-1:0]  bus_data_i,
    output logic               bus_select_o,
    output logic               bus_we_o,
    input  logic               bus_ack_i
);

    bus_state_e        state;
    logic              abort;
    logic [DATA_W-1:0] rd_buf;
    logic              ack_hit;
    logic              abort_eff;
    logic              tmo_hit;

`ifdef CPU_BUS_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0] tmo_cnt;
`else
    // Keeps the timeout parameter referenced when the feature is compiled out.
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
`endif

    // Ack/timeout qualification; a flush in the ack cycle also kills the data.
    always_comb begin
        ack_hit   = (state == BUS_BUSY) && bus_ack_i;
        abort_eff = abort | flush_i;
`ifdef CPU_BUS_TIMEOUT_EN
        tmo_hit   = (state == BUS_BUSY) && !bus_ack_i &&
                    (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
        tmo_hit   = 1'b0;
`endif
    end

    // Pipeline-facing outputs: same-cycle stall request and read data return.
    always_comb begin
        stall_req_o = 1'b0;
        cpu_data_o  = '0;
        case (state)
            BUS_IDLE: begin
                stall_req_o = cpu_ce_i & ~flush_i;
            end
            BUS_BUSY: begin
                if (ack_hit) begin
                    if (!bus_we_o && !abort_eff) begin
                        cpu_data_o = bus_data_i;
                    end
                end else if (!tmo_hit) begin
                    stall_req_o = 1'b1;
                end
            end
            BUS_WAIT_STALL: begin
                if (!flush_i) begin
                    cpu_data_o = rd_buf;
                end
            end
            default: begin
                stall_req_o = 1'b0;
            end
        endcase
    end

    // Initiator FSM with registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BUS_IDLE;
            bus_select_o <= 1'b0;
            bus_we_o     <= 1'b0;
            bus_addr_o   <= '0;
            bus_data_o   <= '0;
            bus_err_o    <= 1'b0;
            rd_buf       <= '0;
            abort        <= 1'b0;
`ifdef CPU_BUS_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            bus_err_o <= 1'b0;
            case (state)
                BUS_IDLE: begin
                    if (cpu_ce_i && !flush_i) begin
                        state        <= BUS_BUSY;
                        bus_select_o <= 1'b1;
                        bus_we_o     <= cpu_we_i;
                        bus_addr_o   <= cpu_addr_i;
                        bus_data_o   <= cpu_data_i;
                        abort        <= 1'b0;
`ifdef CPU_BUS_TIMEOUT_EN
                        tmo_cnt      <= '0;
`endif
                    end
                end
                BUS_BUSY: begin
                    if (bus_ack_i) begin
                        bus_select_o <= 1'b0;
                        bus_we_o     <= 1'b0;
                        rd_buf       <= bus_data_i;
                        abort        <= 1'b0;
                        // A flushed request never parks in WAIT_STALL.
                        if ((stall_i == '0) || abort_eff) begin
                            state <= BUS_IDLE;
                        end else begin
                            state <= BUS_WAIT_STALL;
                        end
                    end else if (tmo_hit) begin
                        bus_select_o <= 1'b0;
                        bus_we_o     <= 1'b0;
                        bus_err_o    <= 1'b1;
                        abort        <= 1'b0;
                        state        <= BUS_IDLE;
                    end else begin
                        // Slave transaction is allowed to finish; only remember the flush.
                        if (flush_i) begin
                            abort <= 1'b1;
                        end
`ifdef CPU_BUS_TIMEOUT_EN
                        tmo_cnt <= TMO_W'(tmo_cnt + 1'b1);
`endif
                    end
                end
                BUS_WAIT_STALL: begin
                    // The request is still asserted here; never reissue it.
                    if (flush_i || (stall_i == '0)) begin
                        state <= BUS_IDLE;
                    end
                end
                default: begin
                    state <= BUS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_initiator.sv
// Self-checking bench for cpu_bus_initiator: directed scenarios followed by
// randomized transactions whose expected per-cycle behaviour is derived from
// each transaction's parameters (ack latency, stall length, flush position).
module tb_cpu_bus_initiator;

    logic        clk;
    logic        rst;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        stall_req_o;
    logic        bus_err_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic [31:0] bus_data_i;
    logic        bus_select_o;
    logic        bus_we_o;
    logic        bus_ack_i;

    int n_checks = 0;
    int n_errors = 0;

    cpu_bus_initiator #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_ce_i    (cpu_ce_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .stall_req_o (stall_req_o),
        .bus_err_o   (bus_err_o),
        .bus_addr_o  (bus_addr_o),
        .bus_data_o  (bus_data_o),
        .bus_data_i  (bus_data_i),
        .bus_select_o(bus_select_o),
        .bus_we_o    (bus_we_o),
        .bus_ack_i   (bus_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One cycle with no request; the initiator must be quiet.
    task automatic idle_cycle(input string tag);
        cpu_ce_i   = 1'b0;
        cpu_we_i   = 1'b0;
        flush_i    = 1'b0;
        stall_i    = '0;
        bus_ack_i  = 1'b0;
        bus_data_i = $urandom;
        @(negedge clk);
        chk({tag, "_sel"},   32'(bus_select_o), 32'd0);
        chk({tag, "_stall"}, 32'(stall_req_o),  32'd0);
        chk({tag, "_rdata"}, cpu_data_o,        32'd0);
        chk({tag, "_err"},   32'(bus_err_o),    32'd0);
        next_cycle();
    endtask

    // One complete transaction, entered with the DUT idle. Cycle 0 presents
    // the request, the slave acks lat cycles after select (cycle lat+1).
    // stall_cyc: cycles (from the ack cycle on) that stall_i is held nonzero.
    // flush_busy: BUSY cycle index (1..lat) carrying a flush pulse, 0 = none.
    // flush_wait: WAIT cycle number (1..stall_cyc) carrying a flush, 0 = none.
    task automatic run_txn(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int lat, input int stall_cyc, input logic [5:0] stall_val,
                           input int flush_busy, input int flush_wait);
        int  ack_c;
        int  last;
        bit  aborted;
        logic [31:0] exp_data;
        ack_c   = lat + 1;
        aborted = (flush_busy != 0);
        if (aborted || stall_cyc == 0)  last = ack_c;
        else if (flush_wait != 0)       last = ack_c + flush_wait;
        else                            last = ack_c + stall_cyc;
        for (int c = 0; c <= last; c++) begin
            cpu_ce_i   = 1'b1;
            cpu_we_i   = we;
            cpu_addr_i = addr;
            cpu_data_i = wdata;
            stall_i    = (c >= ack_c && c < ack_c + stall_cyc) ? stall_val : 6'd0;
            flush_i    = (aborted && c == flush_busy) ||
                         (flush_wait != 0 && c == ack_c + flush_wait);
            if (c == ack_c) begin
                bus_ack_i  = 1'b1;
                bus_data_i = rdata;
            end else begin
                // Stray acks while not BUSY must be ignored.
                bus_ack_i  = (c == 0 || c > ack_c) ? 1'($urandom_range(0, 1)) : 1'b0;
                bus_data_i = $urandom;
            end
            @(negedge clk);
            if (c == ack_c)      exp_data = (!we && !aborted) ? rdata : 32'd0;
            else if (c > ack_c)  exp_data = (flush_wait != 0 && c == ack_c + flush_wait) ? 32'd0 : rdata;
            else                 exp_data = 32'd0;
            chk({tag, "_sel"},   32'(bus_select_o), 32'(c >= 1 && c <= ack_c));
            chk({tag, "_we"},    32'(bus_we_o),     32'(c >= 1 && c <= ack_c && we));
            chk({tag, "_stall"}, 32'(stall_req_o),  32'(c <= lat));
            chk({tag, "_rdata"}, cpu_data_o,        exp_data);
            chk({tag, "_err"},   32'(bus_err_o),    32'd0);
            if (c >= 1 && c <= ack_c) begin
                chk({tag, "_addr"},  bus_addr_o, addr);
                chk({tag, "_wdata"}, bus_data_o, wdata);
            end
            next_cycle();
        end
    endtask

    initial begin
        rst        = 1'b1;
        cpu_ce_i   = 1'b0;
        cpu_we_i   = 1'b0;
        cpu_addr_i = '0;
        cpu_data_i = '0;
        stall_i    = '0;
        flush_i    = 1'b0;
        bus_data_i = '0;
        bus_ack_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_sel",   32'(bus_select_o), 32'd0);
        chk("rst_we",    32'(bus_we_o),     32'd0);
        chk("rst_addr",  bus_addr_o,        32'd0);
        chk("rst_wdata", bus_data_o,        32'd0);
        chk("rst_err",   32'(bus_err_o),    32'd0);
        chk("rst_stall", 32'(stall_req_o),  32'd0);
        chk("rst_rdata", cpu_data_o,        32'd0);
        next_cycle();
        rst = 1'b0;
        idle_cycle("post_rst");

        // Read, ack three cycles after select.
        run_txn("t1_read", 1'b0, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 3, 0, 6'd0, 0, 0);
        idle_cycle("t1_idle");
        // Write, ack one cycle after select.
        run_txn("t2_write", 1'b1, 32'h0000_0104, 32'h1234_5678, 32'hA5A5_0F0F, 1, 0, 6'd0, 0, 0);
        idle_cycle("t2_idle");
        // Read acked while another stage stalls for two more cycles.
        run_txn("t3_wstall", 1'b0, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 2, 3, 6'b000011, 0, 0);
        idle_cycle("t3_idle");
        // Flush in the second BUSY cycle of a read.
        run_txn("t4_flush", 1'b0, 32'h0000_0300, 32'h0, 32'h1111_2222, 3, 2, 6'b000100, 2, 0);
        idle_cycle("t4_idle");
        // Back-to-back reads with zero ack latency.
        run_txn("t5_a", 1'b0, 32'h0000_0010, 32'h0, 32'h0000_AAAA, 0, 0, 6'd0, 0, 0);
        run_txn("t5_b", 1'b0, 32'h0000_0014, 32'h0, 32'h0000_BBBB, 0, 0, 6'd0, 0, 0);
        idle_cycle("t5_idle");

        // Request with flush in IDLE: no transaction starts.
        cpu_ce_i = 1'b1;
        cpu_we_i = 1'b0;
        flush_i  = 1'b1;
        @(negedge clk);
        chk("idle_flush_stall", 32'(stall_req_o), 32'd0);
        next_cycle();
        idle_cycle("idle_flush_after");

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            logic        we;
            int          lat;
            int          sc;
            int          fb;
            int          fw;
            we  = 1'($urandom_range(0, 1));
            lat = $urandom_range(0, 5);
            sc  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            fb  = (lat >= 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
            fw  = (fb == 0 && sc > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, sc) : 0;
            run_txn("rnd", we, $urandom, $urandom, $urandom, lat, sc,
                    6'($urandom_range(1, 63)), fb, fw);
            if ($urandom_range(0, 1) == 1) idle_cycle("rnd_idle");
        end
        idle_cycle("rnd_end");

        // Reset in the middle of a flushed BUSY phase.
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b1;
        cpu_addr_i = 32'h0000_0400;
        cpu_data_i = 32'h5555_AAAA;
        next_cycle();
        flush_i = 1'b1;
        next_cycle();
        flush_i = 1'b0;
        rst     = 1'b1;
        next_cycle();
        rst      = 1'b0;
        cpu_ce_i = 1'b0;
        @(negedge clk);
        chk("mid_rst_sel",   32'(bus_select_o), 32'd0);
        chk("mid_rst_we",    32'(bus_we_o),     32'd0);
        chk("mid_rst_addr",  bus_addr_o,        32'd0);
        chk("mid_rst_wdata", bus_data_o,        32'd0);
        chk("mid_rst_stall", 32'(stall_req_o),  32'd0);
        chk("mid_rst_rdata", cpu_data_o,        32'd0);
        next_cycle();
        run_txn("post_rst_read", 1'b0, 32'h0000_0500, 32'h0, 32'h7777_8888, 1, 0, 6'd0, 0, 0);
        idle_cycle("post_rst_idle");

`ifdef CPU_BUS_TIMEOUT_EN
        // No ack: abort after eight BUSY cycles, stray ack afterwards ignored.
        for (int c = 0; c <= 10; c++) begin
            cpu_ce_i   = (c <= 8);
            cpu_we_i   = 1'b0;
            cpu_addr_i = 32'h0000_0600;
            flush_i    = 1'b0;
            stall_i    = '0;
            bus_ack_i  = (c == 9);
            bus_data_i = $urandom;
            @(negedge clk);
            chk("tmo_sel",   32'(bus_select_o), 32'(c >= 1 && c <= 8));
            chk("tmo_stall", 32'(stall_req_o),  32'(c <= 7));
            chk("tmo_err",   32'(bus_err_o),    32'(c == 9));
            chk("tmo_rdata", cpu_data_o,        32'd0);
            next_cycle();
        end
        idle_cycle("tmo_idle");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
